// File: rtl/cache_wr_ctrl.sv
// Write-port owner for the masked cache line RAM: stores, refill assembly, read-index mux.
// Optional CACHE_REFILL_ERR_EN adds beat_err/refill_err and suppresses erroneous refill writes.
module cache_wr_ctrl #(
    parameter int LINE_W  = 128,
    parameter int BEAT_W  = 64,
    parameter int INDEX_W = 6,
    localparam int NBEAT  = LINE_W / BEAT_W,
    localparam int WW     = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_stall,
    input  logic               store_valid,
    output logic               store_ready,
    input  logic [INDEX_W-1:0] store_index,
    input  logic [WW-1:0]      store_word,
    input  logic [BEAT_W/8-1:0] store_be,
    input  logic [BEAT_W-1:0]  store_data,
    input  logic               refill_start,
    output logic               refill_ready,
    input  logic [INDEX_W-1:0] refill_index,
    input  logic               beat_valid,
    input  logic [BEAT_W-1:0]  beat_data,
`ifdef CACHE_REFILL_ERR_EN
    input  logic               beat_err,
    output logic               refill_err,
`endif
    output logic               refill_done,
    output logic [INDEX_W-1:0] ram_entry_index,
    output logic               ram_wen,
    output logic [LINE_W-1:0]  ram_wmask,
    output logic [LINE_W-1:0]  ram_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t               r_state;
    logic [WW-1:0]        r_cnt;
    logic [LINE_W-1:0]    r_line;
    logic [INDEX_W-1:0]   r_ridx;
    logic [INDEX_W-1:0]   r_sidx;
    logic [WW-1:0]        r_sword;
    logic [BEAT_W/8-1:0]  r_sbe;
    logic [BEAT_W-1:0]    r_sdata;
`ifdef CACHE_REFILL_ERR_EN
    logic                 r_err;
`endif

    logic                 w_wen;
    logic                 w_done;
    logic [INDEX_W-1:0]   w_idx;
    logic [LINE_W-1:0]    w_wmask;
    logic [LINE_W-1:0]    w_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_ridx  <= '0;
            r_sidx  <= '0;
            r_sword <= '0;
            r_sbe   <= '0;
            r_sdata <= '0;
`ifdef CACHE_REFILL_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    // refill has priority over a same-cycle store
                    if (refill_start) begin
                        r_ridx  <= refill_index;
                        r_cnt   <= '0;
                        r_state <= FILL;
`ifdef CACHE_REFILL_ERR_EN
                        r_err   <= 1'b0;
`endif
                    end else if (store_valid) begin
                        r_sidx  <= store_index;
                        r_sword <= store_word;
                        r_sbe   <= store_be;
                        r_sdata <= store_data;
                        r_state <= STORE;
                    end
                end
                FILL: begin
                    if (beat_valid) begin
                        r_line[int'(r_cnt)*BEAT_W +: BEAT_W] <= beat_data;
                        r_cnt <= r_cnt + 1'b1;
`ifdef CACHE_REFILL_ERR_EN
                        if (beat_err)
                            r_err <= 1'b1;
`endif
                        if (int'(r_cnt) == NBEAT - 1)
                            r_state <= WRITE;
                    end
                end
                WRITE:   r_state <= IDLE;
                STORE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_wen   = 1'b0;
        w_done  = 1'b0;
        w_idx   = rd_index;
        w_wmask = '0;
        w_wdata = '0;
        unique case (r_state)
            WRITE: begin
                w_done  = 1'b1;
                w_wen   = 1'b1;
                w_idx   = r_ridx;
                w_wmask = '1;
                w_wdata = r_line;
`ifdef CACHE_REFILL_ERR_EN
                if (r_err) begin
                    w_wen   = 1'b0;
                    w_idx   = rd_index;
                    w_wmask = '0;
                    w_wdata = '0;
                end
`endif
            end
            STORE: begin
                w_wen   = 1'b1;
                w_idx   = r_sidx;
                w_wdata = {NBEAT{r_sdata}};
                for (int w = 0; w < NBEAT; w++) begin
                    for (int b = 0; b < BEAT_W/8; b++) begin
                        if (int'(r_sword) == w && r_sbe[b])
                            w_wmask[w*BEAT_W + 8*b +: 8] = 8'hFF;
                    end
                end
            end
            default: ;
        endcase
    end

    assign refill_ready    = rstn && (r_state == IDLE);
    assign store_ready     = refill_ready && !refill_start;
    assign refill_done     = w_done;
    assign ram_wen         = w_wen;
    assign rd_stall        = w_wen;
    assign ram_entry_index = w_idx;
    assign ram_wmask       = w_wmask;
    assign ram_wdata       = w_wdata;
`ifdef CACHE_REFILL_ERR_EN
    assign refill_err      = w_done && r_err;
`endif

endmodule

// File: doc/cache_wr_ctrl.md
# cache_wr_ctrl

Write-port controller that sits directly upstream of the masked cache line RAM and owns its single index/write port. It takes CPU store requests (byte-enabled 64-bit words) and memory refill beats, assembles full lines from beats, and issues one RAM write per store or completed refill. It also multiplexes the lookup read index onto the shared RAM index port whenever no write is in progress.

## Interface
- LINE_W, 128, cache line width; must equal the RAM line width
- BEAT_W, 64, refill beat and store word width; LINE_W/BEAT_W = NBEAT = 2
- INDEX_W, 6, RAM entry index width
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- rd_index  in  INDEX_W  lookup index, driven to RAM when no write
- rd_stall  out  1  high when the RAM port is taken by a write this cycle
- store_valid  in  1  store request
- store_ready  out  1  store accepted when valid&ready
- store_index  in  INDEX_W  target entry
- store_word  in  log2(NBEAT)  word slot within line
- store_be  in  BEAT_W/8  byte enables
- store_data  in  BEAT_W  store data
- refill_start  in  1  begin refill of refill_index (accepted when refill_ready)
- refill_ready  out  1  controller idle
- refill_index  in  INDEX_W  refill target entry
- beat_valid  in  1  refill beat present
- beat_data  in  BEAT_W  beat data, beat 0 = low word
- refill_done  out  1  one-cycle pulse with the refill RAM write
- ram_entry_index  out  INDEX_W  to RAM entry_index
- ram_wen  out  1  to RAM wen
- ram_wmask  out  LINE_W  to RAM wmask
- ram_wdata  out  LINE_W  to RAM wdata

## Operation
- States: IDLE, FILL, WRITE (refill line), STORE (store word).
- IDLE: refill_ready=1; store_ready = !refill_start. refill_start → capture refill_index, beat count=0, go FILL (refill wins over simultaneous store). Else store_valid → capture index/word/be/data, go STORE.
- FILL: each beat_valid writes beat_data into line buffer slot [cnt*BEAT_W +: BEAT_W], cnt+1; beat with cnt==NBEAT-1 → WRITE. beat_valid outside FILL ignored; refill_start outside IDLE ignored.
- WRITE: ram_wen=1, ram_wmask all ones, ram_wdata=line buffer, ram_entry_index=refill index, refill_done=1; → IDLE.
- STORE: ram_wen=1, ram_wmask bits [word*BEAT_W+8i +: 8]=0xFF for each set store_be[i], all others 0; ram_wdata = store_data replicated into each word slot; ram_entry_index=store index; → IDLE.
- Not writing: ram_entry_index=rd_index, ram_wen=0, ram_wmask=0, rd_stall=0. rd_stall = ram_wen.
- store_be=0 still performs a (no-op) write cycle.

## Timing
- Reset: state IDLE, cnt 0, buffer 0, ram_wen 0, ram_wmask 0, refill_done 0; store_ready and refill_ready forced 0 while rstn low.
- Store accepted in cycle T → ram_wen in T+1, RAM updated at end of T+1; store_ready 0 in T+1; next store accepted T+2 at earliest.
- Refill: start in T, beats in any later cycles (gaps allowed), last beat in cycle L → WRITE/refill_done in L+1, refill_ready 1 in L+2.
- Reset mid-refill: partial line discarded, no RAM write, refill_done not pulsed.
- All RAM-facing outputs decode from registered state only; no combinational path from store_*/beat_* to ram_*.

## Configuration
- CACHE_REFILL_ERR_EN defined: adds input beat_err (1) and output refill_err (1). Any beat with beat_err=1 sets a sticky error flag; at end of refill the WRITE state suppresses ram_wen (RAM untouched, rd_stall 0) while refill_done pulses with refill_err=1. Flag clears on next refill_start.
- Undefined: ports absent, every completed refill writes the RAM.

## Test plan
- Reset, then store index 5, word 1, be 0x0F, data 0x1122334455667788 → next cycle ram_wen=1, ram_entry_index=5, ram_wmask=0x00000000FFFFFFFF in bits [127:64], low 64 bits 0; rd_stall=1.
- Refill index 9, beats 0xA…A then 0xB…B with 2 idle cycles between → cycle after 2nd beat: ram_wmask all ones, ram_wdata={0xB…B,0xA…A}, refill_done=1 for one cycle.
- refill_start and store_valid same IDLE cycle → store_ready=0, refill proceeds; store accepted only after refill_done + 1 cycle.
- rstn asserted after first beat of refill → no ram_wen ever, state IDLE, new refill after reset produces only its own beats.
- No write activity, rd_index sweeps 0..63 → ram_entry_index follows rd_index each cycle, ram_wen=0.
- CACHE_REFILL_ERR_EN: beat_err=1 on beat 0 → refill_done=1, refill_err=1, ram_wen=0; following clean refill → refill_err=0, line written.
